// File: rtl/axi_sim_sram_if.sv
// AXI4 bus bundle (32-bit data, 4-bit ID) between a core master and the simulation SRAM slave.
interface axi_sim_sram_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        input  arready, rid, rdata, rresp, rlast, rvalid,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        output arready, rid, rdata, rresp, rlast, rvalid,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi_sim_sram.sv
// AXI slave word-array memory with independent read and write burst engines.
// Optional macro AXI_SIM_SRAM_WRAP_BURST_EN enables WRAP address sequencing.
module axi_sim_sram #(
    parameter int          MEM_WORDS = 16384,
    parameter logic [31:0] BASE_ADDR = 32'h1c000000
) (
    input logic          clk,
    input logic          rst,
    axi_sim_sram_if.slave bus
);
    localparam int IDX_W = $clog2(MEM_WORDS);

    typedef enum logic {R_IDLE, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [31:0] mem [MEM_WORDS];

    function automatic logic in_range(input logic [31:0] addr);
        logic [31:0] word;
        word = (addr - BASE_ADDR) >> 2;
        return (addr >= BASE_ADDR) && (word < 32'(MEM_WORDS));
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 2);
    endfunction

`ifdef AXI_SIM_SRAM_WRAP_BURST_EN
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                              input logic [1:0] burst);
        logic [31:0] nxt;
        logic [31:0] mask;
        nxt  = (burst == 2'b00) ? addr : addr + 32'd4;
        // (len+1)*4-1 is len*4+3 for the window mask
        mask = {22'd0, len, 2'b11};
        if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
            nxt = (addr & ~mask) | ((addr + 32'd4) & mask);
        return nxt;
    endfunction
`else
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len_unused,
                                              input logic [1:0] burst);
        return (burst == 2'b00) ? addr : addr + 32'd4;
    endfunction
`endif

    r_state_t    r_state, r_state_next;
    logic [3:0]  r_id;
    logic [31:0] r_addr;
    logic [7:0]  r_len, r_cnt;
    logic [1:0]  r_burst;
    logic        r_in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_burst <= '0;
        end else begin
            r_state <= r_state_next;
            if (r_state == R_IDLE && bus.arvalid) begin
                r_id    <= bus.arid;
                r_addr  <= bus.araddr;
                r_len   <= bus.arlen;
                r_burst <= bus.arburst;
                r_cnt   <= '0;
            end else if (r_state == R_BURST && bus.rready && r_cnt != r_len) begin
                r_cnt  <= r_cnt + 8'd1;
                r_addr <= next_addr(r_addr, r_len, r_burst);
            end
        end
    end

    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE:  if (bus.arvalid) r_state_next = R_BURST;
            R_BURST: if (bus.rready && r_cnt == r_len) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    // Read data is an asynchronous array lookup, so a same-cycle write is not yet visible
    assign r_in_range  = in_range(r_addr);
    assign bus.arready = (r_state == R_IDLE);
    assign bus.rvalid  = (r_state == R_BURST);
    assign bus.rid     = r_id;
    assign bus.rlast   = bus.rvalid && (r_cnt == r_len);
    assign bus.rdata   = (bus.rvalid && r_in_range) ? mem[word_idx(r_addr)] : 32'd0;
    assign bus.rresp   = (bus.rvalid && !r_in_range) ? 2'b10 : 2'b00;

    w_state_t    w_state, w_state_next;
    logic [3:0]  w_id;
    logic [31:0] w_addr;
    logic [7:0]  w_len, w_cnt;
    logic [1:0]  w_burst;
    logic        w_err;
    logic        w_in_range;
    logic        w_at_len;

    assign w_in_range = in_range(w_addr);
    assign w_at_len   = (w_cnt == w_len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
        end else begin
            w_state <= w_state_next;
            if (w_state == W_IDLE && bus.awvalid) begin
                w_id    <= bus.awid;
                w_addr  <= bus.awaddr;
                w_len   <= bus.awlen;
                w_burst <= bus.awburst;
                w_cnt   <= '0;
                w_err   <= 1'b0;
            end else if (w_state == W_DATA && bus.wvalid) begin
                if (!w_in_range || (bus.wlast != w_at_len))
                    w_err <= 1'b1;
                w_cnt  <= w_cnt + 8'd1;
                w_addr <= next_addr(w_addr, w_len, w_burst);
            end
        end
    end

    always_comb begin
        w_state_next = w_state;
        case (w_state)
            W_IDLE:  if (bus.awvalid) w_state_next = W_DATA;
            W_DATA:  if (bus.wvalid && (bus.wlast || w_at_len)) w_state_next = W_RESP;
            W_RESP:  if (bus.bready) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_state == W_DATA && bus.wvalid && w_in_range) begin
            for (int i = 0; i < 4; i++)
                if (bus.wstrb[i])
                    mem[word_idx(w_addr)][8*i +: 8] <= bus.wdata[8*i +: 8];
        end
    end

    assign bus.awready = (w_state == W_IDLE);
    assign bus.wready  = (w_state == W_DATA);
    assign bus.bvalid  = (w_state == W_RESP);
    assign bus.bid     = w_id;
    assign bus.bresp   = (bus.bvalid && w_err) ? 2'b10 : 2'b00;

    // Beat size is fixed at 32 bits; the size fields are accepted and ignored
    logic unused_size;
    assign unused_size = ^{bus.arsize, bus.awsize};
endmodule

// File: tb/tb_axi_sim_sram.sv
// Directed plus randomized bench for axi_sim_sram against a word-level memory model.
module tb_axi_sim_sram;
    localparam int          MEM_WORDS = 16384;
    localparam logic [31:0] BASE      = 32'h1c000000;
    localparam int          LIMIT     = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_sim_sram_if bus();
    axi_sim_sram #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] model [int];
    logic [31:0] wq_data[$];
    logic [3:0]  wq_strb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic in_rng(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) >> 2) < 32'(MEM_WORDS));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // Address of beat i computed directly from the burst rules
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                              input logic [1:0] burst, input int i);
        if (burst == 2'b00) return start;
`ifdef AXI_SIM_SRAM_WRAP_BURST_EN
        if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            int unsigned size;
            int unsigned base;
            size = (len + 1) * 4;
            base = (start / size) * size;
            return base + ((start - base + 4 * i) % size);
        end
`endif
        return start + 32'(4 * i);
    endfunction

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input int wlast_at);
        int t;
        int nbeats;
        logic exp_err;
        logic [31:0] a;
        logic [31:0] w;
        logic [3:0] s;
        nbeats  = ((wlast_at < len) ? wlast_at : len) + 1;
        exp_err = (wlast_at != len);
        @(negedge clk);
        bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len);
        bus.awburst = burst; bus.awsize = 3'b010; bus.awvalid = 1'b1;
        t = 0;
        while (!bus.awready && t < LIMIT) begin @(negedge clk); t++; end
        check("aw_timeout", 32'(t < LIMIT), 32'd1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            w = (i < wq_data.size()) ? wq_data[i] : 32'h0;
            s = (i < wq_strb.size()) ? wq_strb[i] : 4'hf;
            bus.wdata = w; bus.wstrb = s; bus.wlast = (i == wlast_at); bus.wvalid = 1'b1;
            @(negedge clk);
            t = 0;
            while (!bus.wready && t < LIMIT) begin @(negedge clk); t++; end
            check("w_timeout", 32'(t < LIMIT), 32'd1);
            a = beat_addr(addr, len, burst, i);
            if (in_rng(a)) begin
                logic [31:0] old;
                old = model.exists(widx(a)) ? model[widx(a)] : 32'h0;
                for (int b = 0; b < 4; b++) if (s[b]) old[8*b +: 8] = w[8*b +: 8];
                model[widx(a)] = old;
            end else begin
                exp_err = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
        @(negedge clk);
        t = 0;
        while (!bus.bvalid && t < LIMIT) begin @(negedge clk); t++; end
        check("b_timeout", 32'(t < LIMIT), 32'd1);
        check("bid", 32'(bus.bid), 32'(id));
        check("bresp", 32'(bus.bresp), exp_err ? 32'd2 : 32'd0);
        @(posedge clk); #1;
        bus.bready = 1'b0;
    endtask

    // mode 0: rready always high, 1: pattern 1,0,0,1, 2: random
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input int mode);
        int t;
        int beat;
        int cyc;
        logic rr;
        logic [31:0] a;
        logic [3:0] pat;
        pat = 4'b1001;
        @(negedge clk);
        bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len);
        bus.arburst = burst; bus.arsize = 3'b010; bus.arvalid = 1'b1;
        t = 0;
        while (!bus.arready && t < LIMIT) begin @(negedge clk); t++; end
        check("ar_timeout", 32'(t < LIMIT), 32'd1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        beat = 0;
        cyc  = 0;
        while (beat <= len && cyc < 2000) begin
            @(negedge clk);
            rr = (mode == 0) ? 1'b1 : (mode == 1) ? pat[3 - (cyc % 4)] : 1'($urandom_range(0, 1));
            cyc++;
            a = beat_addr(addr, len, burst, beat);
            check("rvalid", 32'(bus.rvalid), 32'd1);
            check("rid", 32'(bus.rid), 32'(id));
            check("rlast", 32'(bus.rlast), 32'(beat == len));
            if (!in_rng(a)) begin
                check("rdata_oob", bus.rdata, 32'h0);
                check("rresp_oob", 32'(bus.rresp), 32'd2);
            end else begin
                check("rresp", 32'(bus.rresp), 32'd0);
                if (model.exists(widx(a))) check("rdata", bus.rdata, model[widx(a)]);
            end
            bus.rready = rr;
            @(posedge clk); #1;
            if (rr) beat++;
        end
        check("r_budget", 32'(cyc < 2000), 32'd1);
        bus.rready = 1'b0;
        @(negedge clk);
        check("r_idle_rvalid", 32'(bus.rvalid), 32'd0);
        check("r_idle_arready", 32'(bus.arready), 32'd1);
    endtask

    initial begin
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'b010;
        bus.arburst = 2'b01; bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'b010;
        bus.awburst = 2'b01; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_arready", 32'(bus.arready), 32'd1);
        check("rst_awready", 32'(bus.awready), 32'd1);
        check("rst_rvalid", 32'(bus.rvalid), 32'd0);
        check("rst_rlast", 32'(bus.rlast), 32'd0);
        check("rst_rid", 32'(bus.rid), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_rresp", 32'(bus.rresp), 32'd0);
        check("rst_wready", 32'(bus.wready), 32'd0);
        check("rst_bvalid", 32'(bus.bvalid), 32'd0);
        check("rst_bid", 32'(bus.bid), 32'd0);
        check("rst_bresp", 32'(bus.bresp), 32'd0);
        rst = 1'b0;

        // W beats before any AW must stall
        bus.wvalid = 1'b1;
        @(negedge clk);
        check("w_before_aw", 32'(bus.wready), 32'd0);
        bus.wvalid = 1'b0;

        wq_data = {32'hdeadbeef}; wq_strb = {4'hf};
        do_write(4'h5, BASE, 0, 2'b01, 0);
        do_read(4'h3, BASE, 0, 2'b01, 0);
        check("single_word", model[0], 32'hdeadbeef);

        wq_data = {}; wq_strb = {};
        for (int i = 0; i < 8; i++) wq_data.push_back(32'h11111111 * i);
        do_write(4'h1, BASE, 7, 2'b01, 7);
        do_read(4'h2, BASE, 7, 2'b01, 0);
        do_read(4'h9, BASE + 32'd4, 3, 2'b01, 1);

        wq_data = {32'hffffffff}; wq_strb = {4'hf};
        do_write(4'h0, BASE + 32'd40, 0, 2'b01, 0);
        wq_data = {32'h00000000}; wq_strb = {4'b0101};
        do_write(4'h0, BASE + 32'd40, 0, 2'b01, 0);
        check("strobe_model", model[10], 32'hff00ff00);
        do_read(4'h4, BASE + 32'd40, 0, 2'b01, 0);

        do_read(4'h6, 32'h1bfffffc, 0, 2'b01, 0);
        wq_data = {32'ha0, 32'ha1, 32'ha2, 32'ha3}; wq_strb = {};
        do_write(4'h7, BASE + 32'd80, 3, 2'b01, 3);
        wq_data = {32'hb0, 32'hb1, 32'hb2, 32'hb3};
        do_write(4'h8, BASE + 32'd80, 3, 2'b01, 2);
        do_read(4'h8, BASE + 32'd80, 3, 2'b01, 0);
        wq_data = {32'hc0, 32'hc1};
        do_write(4'ha, BASE + 32'((MEM_WORDS - 1) * 4), 1, 2'b01, 1);
        do_read(4'hb, BASE + 32'((MEM_WORDS - 1) * 4), 1, 2'b01, 1);

        do_read(4'hc, BASE + 32'h8, 3, 2'b10, 0);
        do_read(4'hd, BASE + 32'hc, 2, 2'b00, 1);

        for (int n = 0; n < 8; n++) begin
            logic [31:0] addr;
            logic [1:0] burst;
            int len;
            int lens[6];
            lens  = '{0, 1, 3, 7, 2, 5};
            len   = lens[$urandom_range(0, 5)];
            burst = 2'($urandom_range(0, 2));
            addr  = BASE + 32'(4 * $urandom_range(32, 200));
            wq_data = {}; wq_strb = {};
            for (int i = 0; i <= len; i++) wq_data.push_back($urandom);
            do_write(4'($urandom_range(0, 15)), addr, len, burst, len);
            do_read(4'($urandom_range(0, 15)), addr, len, burst, 2);
        end

        // Reset in the middle of a read burst abandons it
        @(negedge clk);
        bus.arid = 4'he; bus.araddr = BASE; bus.arlen = 8'd3; bus.arburst = 2'b01; bus.arvalid = 1'b1;
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        @(negedge clk);
        check("pre_rst_rvalid", 32'(bus.rvalid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_rvalid", 32'(bus.rvalid), 32'd0);
        check("mid_rst_arready", 32'(bus.arready), 32'd1);
        check("mid_rst_rid", 32'(bus.rid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_read(4'h1, BASE + 32'd80, 3, 2'b01, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
